vdma_lsram_reader: RTL and testbench

Read-side engine for the VDMA line-buffer LSRAM. On a START command it issues a burst of sequential reads (REN/RADDR) to the RAM read port, absorbs the RAM's fixed read latency, and presents the words as a valid/ready stream with a LAST marker. A credit-limited skid FIFO guarantees no word is lost under downstream back-pressure. It is the consumer that sits opposite the line-buffer write path.

---
 rtl/vdma_lsram_reader.sv | 171 +++++++++++++++++
 tb/tb_vdma_lsram_reader.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vdma_lsram_reader.sv
// VDMA line-buffer read engine: burst-reads the LSRAM, absorbs its read latency
// and streams the words out through a credit-limited skid FIFO.
module vdma_lsram_reader #(
    parameter int RWIDTH     = 32,
    parameter int ADDR_WIDTH = 7,
    parameter int RD_LATENCY = 2,
    parameter int SKID_DEPTH = 4
) (
    input  logic                  CLOCK,
    input  logic                  RESET,
    input  logic                  START,
    input  logic [ADDR_WIDTH-1:0] START_ADDR,
    input  logic [ADDR_WIDTH:0]   LEN,
    output logic                  BUSY,
    output logic                  DONE,
    output logic                  RAM_REN,
    output logic [ADDR_WIDTH-1:0] RAM_RADDR,
    input  logic [RWIDTH-1:0]     RAM_RDATA,
    output logic [RWIDTH-1:0]     M_DATA,
    output logic                  M_VALID,
    input  logic                  M_READY,
    output logic                  M_LAST
);
    localparam int LW = ADDR_WIDTH + 1;
    localparam int CW = $clog2(SKID_DEPTH + 1);
    localparam int PW = (SKID_DEPTH > 1) ? $clog2(SKID_DEPTH) : 1;

    typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

    state_t                state_q, state_d;
    logic                  busy_q, busy_d, done_q, done_d, ren_q, ren_d;
    logic [ADDR_WIDTH-1:0] raddr_q, raddr_d;
    logic [LW-1:0]         len_q, len_d, issued_q, issued_d;
    logic [CW-1:0]         inflight_q, inflight_d, cnt_q, cnt_d;
    logic [RD_LATENCY-1:0] pv_q, pv_d, pl_q, pl_d;
    logic [RWIDTH-1:0]     mem_q [SKID_DEPTH];
    logic [RWIDTH-1:0]     mem_d [SKID_DEPTH];
    logic [SKID_DEPTH-1:0] mlast_q, mlast_d;
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [RWIDTH-1:0]     m_data_q, m_data_d;
    logic                  m_valid_q, m_valid_d, m_last_q, m_last_d;
    logic                  push, pop, last_issue;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(SKID_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_comb begin
        push       = pv_q[RD_LATENCY-1];
        pop        = m_valid_q && M_READY;
        last_issue = ren_q && (issued_q == len_q - LW'(1));

        state_d  = state_q;
        len_d    = len_q;
        done_d   = 1'b0;
        issued_d = issued_q + LW'(ren_q);
        raddr_d  = ren_q ? raddr_q + ADDR_WIDTH'(1) : raddr_q;

        case (state_q)
            IDLE: begin
                if (START) begin
                    if (LEN != '0) begin
                        state_d  = READ;
                        len_d    = LEN;
                        raddr_d  = START_ADDR;
                        issued_d = '0;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            READ:    if (last_issue) state_d = DRAIN;
            DRAIN: begin
                if (pop && m_last_q) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        pv_d[0] = ren_q;
        pl_d[0] = last_issue;
        for (int unsigned i = 1; i < RD_LATENCY; i++) begin
            pv_d[i] = pv_q[i-1];
            pl_d[i] = pl_q[i-1];
        end

        inflight_d = inflight_q + CW'(ren_q) - CW'(push);
        cnt_d      = cnt_q + CW'(push) - CW'(pop);
        wr_ptr_d   = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d   = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;

        mem_d   = mem_q;
        mlast_d = mlast_q;
        if (push) begin
            mem_d[wr_ptr_q]   = RAM_RDATA;
            mlast_d[wr_ptr_q] = pl_q[RD_LATENCY-1];
        end

        // Next head bypasses the array when the word being written becomes the head.
        m_valid_d = (cnt_d != '0);
        m_data_d  = m_data_q;
        m_last_d  = 1'b0;
        if (push && (wr_ptr_q == rd_ptr_d)) begin
            m_data_d = RAM_RDATA;
            m_last_d = pl_q[RD_LATENCY-1];
        end else if (cnt_d != '0) begin
            m_data_d = mem_q[rd_ptr_d];
            m_last_d = mlast_q[rd_ptr_d];
        end

        // Each issued read reserves a FIFO slot until it is popped.
        ren_d  = (state_d == READ) && (issued_d < len_d) &&
                 (({1'b0, inflight_d} + {1'b0, cnt_d}) < (CW+1)'(SKID_DEPTH));
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state_q    <= IDLE;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            ren_q      <= 1'b0;
            raddr_q    <= '0;
            len_q      <= '0;
            issued_q   <= '0;
            inflight_q <= '0;
            cnt_q      <= '0;
            pv_q       <= '0;
            pl_q       <= '0;
            mlast_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            m_data_q   <= '0;
            m_valid_q  <= 1'b0;
            m_last_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            ren_q      <= ren_d;
            raddr_q    <= raddr_d;
            len_q      <= len_d;
            issued_q   <= issued_d;
            inflight_q <= inflight_d;
            cnt_q      <= cnt_d;
            pv_q       <= pv_d;
            pl_q       <= pl_d;
            mlast_q    <= mlast_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            m_data_q   <= m_data_d;
            m_valid_q  <= m_valid_d;
            m_last_q   <= m_last_d;
        end
    end

    always_ff @(posedge CLOCK) begin
        mem_q <= mem_d;
    end

    assign BUSY      = busy_q;
    assign DONE      = done_q;
    assign RAM_REN   = ren_q;
    assign RAM_RADDR = raddr_q;
    assign M_DATA    = m_data_q;
    assign M_VALID   = m_valid_q;
    assign M_LAST    = m_last_q;

endmodule

// File: tb/tb_vdma_lsram_reader.sv
// Directed bench for vdma_lsram_reader with a 2-cycle pipelined RAM model returning
// a tag OR'd with the read address.
module tb_vdma_lsram_reader;
    logic        CLOCK = 1'b0;
    logic        RESET, START, M_READY;
    logic [6:0]  START_ADDR;
    logic [7:0]  LEN;
    logic        BUSY, DONE, RAM_REN, M_VALID, M_LAST;
    logic [6:0]  RAM_RADDR;
    logic [31:0] RAM_RDATA, M_DATA;

    int tests = 0;
    int fails = 0;

    logic [31:0] beats [$];
    logic        lasts [$];
    logic [6:0]  raddrs [$];
    int          done_cnt, done_cyc, first_vld, max_occ, unstable;
    bit          busy_seen;

    vdma_lsram_reader #(.RWIDTH(32), .ADDR_WIDTH(7), .RD_LATENCY(2), .SKID_DEPTH(4)) dut (
        .CLOCK(CLOCK), .RESET(RESET), .START(START), .START_ADDR(START_ADDR), .LEN(LEN),
        .BUSY(BUSY), .DONE(DONE), .RAM_REN(RAM_REN), .RAM_RADDR(RAM_RADDR),
        .RAM_RDATA(RAM_RDATA), .M_DATA(M_DATA), .M_VALID(M_VALID), .M_READY(M_READY),
        .M_LAST(M_LAST)
    );

    always #5 CLOCK = ~CLOCK;

    logic [6:0] ram_p1, ram_p2;
    always @(posedge CLOCK) begin
        ram_p1 <= RAM_RADDR;
        ram_p2 <= ram_p1;
    end
    assign RAM_RDATA = 32'hD000_0000 | {25'd0, ram_p2};

    always @(posedge CLOCK) begin
        if (!RESET && dut.push && dut.cnt_q == 4) begin
            fails++;
            $display("FAIL fifo_overflow: write into full FIFO at %0t", $time);
        end
    end

    function automatic logic [31:0] exp_data(input logic [6:0] a);
        return 32'hD000_0000 | {25'd0, a};
    endfunction

    // Runs one command, recording beats, read addresses, DONE and stability info.
    task automatic run_cmd(input logic [6:0] addr, input logic [7:0] len,
                           input bit bp, input bit second);
        int pops = 0;
        int occ;
        bit prev_stall = 0;
        logic [31:0] prev_data = '0;
        logic prev_last = 0;
        beats.delete(); lasts.delete(); raddrs.delete();
        done_cnt = 0; done_cyc = -1; first_vld = -1; max_occ = 0; unstable = 0;
        busy_seen = 0;
        @(negedge CLOCK);
        START = 1; START_ADDR = addr; LEN = len; M_READY = 1;
        for (int c = 1; c <= 400; c++) begin
            @(negedge CLOCK);
            START = second && (c == 3);
            if (second) begin START_ADDR = 7'd50; LEN = 8'd3; end
            M_READY = bp ? ((c % 4 == 0) || (c % 4 == 3)) : 1'b1;
            if (RAM_REN) begin
                raddrs.push_back(RAM_RADDR);
                occ = raddrs.size() - pops;
                if (occ > max_occ) max_occ = occ;
            end
            if (prev_stall && (!M_VALID || M_DATA !== prev_data || M_LAST !== prev_last))
                unstable++;
            if (M_VALID && first_vld < 0) first_vld = c;
            if (M_VALID && M_READY) begin
                beats.push_back(M_DATA);
                lasts.push_back(M_LAST);
                pops++;
            end
            prev_stall = M_VALID && !M_READY;
            prev_data  = M_DATA;
            prev_last  = M_LAST;
            if (DONE) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = c;
            end
            if (BUSY) busy_seen = 1;
            if (done_cyc >= 0 && c >= done_cyc + 6) break;
        end
        START = 0;
        M_READY = 1;
    endtask

    task automatic test_reset;
        RESET = 1; START = 0; START_ADDR = '0; LEN = '0; M_READY = 1;
        repeat (3) @(negedge CLOCK);
        tests++;
        if ({BUSY, DONE, RAM_REN, RAM_RADDR, M_VALID, M_LAST, M_DATA} !== '0) begin
            fails++;
            $display("FAIL reset_state: got busy=%b done=%b ren=%b raddr=%0d vld=%b last=%b data=%h expected all 0",
                     BUSY, DONE, RAM_REN, RAM_RADDR, M_VALID, M_LAST, M_DATA);
        end
        RESET = 0;
        @(negedge CLOCK);
    endtask

    task automatic test_basic;
        logic [11:0] got, exp;
        logic [31:0] edata;
        @(negedge CLOCK);
        START = 1; START_ADDR = 7'd5; LEN = 8'd8; M_READY = 1;
        for (int c = 1; c <= 13; c++) begin
            @(negedge CLOCK);
            START = 0;
            exp = {(c >= 1 && c <= 8), (c >= 1 && c <= 8) ? 7'(5 + c - 1) : 7'd0,
                   (c >= 1 && c <= 11), (c == 12), (c >= 4 && c <= 11), (c == 11)};
            got = {RAM_REN, RAM_REN ? RAM_RADDR : 7'd0, BUSY, DONE, M_VALID, M_LAST};
            tests++;
            if (got !== exp) begin
                fails++;
                $display("FAIL basic_ctrl c%0d: got {ren,raddr,busy,done,vld,last}=%h expected %h",
                         c, got, exp);
            end
            if (c >= 4 && c <= 11) begin
                edata = exp_data(7'(5 + c - 4));
                tests++;
                if (M_DATA !== edata) begin
                    fails++;
                    $display("FAIL basic_data c%0d: got %h expected %h", c, M_DATA, edata);
                end
            end
        end
    endtask

    task automatic test_wrap;
        int bad = 0;
        logic [6:0] ea;
        run_cmd(7'd126, 8'd4, 0, 0);
        for (int i = 0; i < 4; i++) begin
            ea = 7'(126 + i);
            if (i >= raddrs.size() || raddrs[i] !== ea) bad++;
            if (i >= beats.size() || beats[i] !== exp_data(ea)) bad++;
        end
        tests++;
        if (bad != 0 || raddrs.size() != 4 || beats.size() != 4) begin
            fails++;
            $display("FAIL wrap_seq: got %0d errors, %0d reads, %0d beats expected 0,4,4",
                     bad, raddrs.size(), beats.size());
        end
        tests++;
        if (first_vld != 4 || lasts.size() != 4 || lasts[3] !== 1'b1) begin
            fails++;
            $display("FAIL wrap_timing: got first_vld=%0d beats=%0d expected 4 and last on beat 3",
                     first_vld, lasts.size());
        end
    endtask

    task automatic test_backpressure;
        int bad = 0;
        int nlast = 0;
        run_cmd(7'd40, 8'd16, 1, 0);
        for (int i = 0; i < beats.size(); i++) begin
            if (beats[i] !== exp_data(7'(40 + i))) bad++;
            if (lasts[i]) nlast++;
        end
        tests++;
        if (beats.size() != 16 || bad != 0) begin
            fails++;
            $display("FAIL bp_data: got %0d beats %0d wrong expected 16 beats 0 wrong",
                     beats.size(), bad);
        end
        tests++;
        if (nlast != 1 || beats.size() != 16 || lasts[15] !== 1'b1) begin
            fails++;
            $display("FAIL bp_last: got %0d last markers expected 1 on beat 15", nlast);
        end
        tests++;
        if (max_occ != 4) begin
            fails++;
            $display("FAIL bp_credit: got max occupancy %0d expected 4", max_occ);
        end
        tests++;
        if (unstable != 0) begin
            fails++;
            $display("FAIL bp_stable: got %0d unstable stall cycles expected 0", unstable);
        end
        tests++;
        if (done_cnt != 1) begin
            fails++;
            $display("FAIL bp_done: got %0d DONE pulses expected 1", done_cnt);
        end
    endtask

    task automatic test_len0;
        run_cmd(7'd9, 8'd0, 0, 0);
        tests++;
        if (done_cnt != 1 || done_cyc != 1) begin
            fails++;
            $display("FAIL len0_done: got %0d pulses at cycle %0d expected 1 at cycle 1",
                     done_cnt, done_cyc);
        end
        tests++;
        if (raddrs.size() != 0 || first_vld != -1 || busy_seen) begin
            fails++;
            $display("FAIL len0_quiet: got reads=%0d first_vld=%0d busy=%b expected 0,-1,0",
                     raddrs.size(), first_vld, busy_seen);
        end
    endtask

    task automatic test_ignored_start;
        int bad = 0;
        run_cmd(7'd10, 8'd6, 0, 1);
        for (int i = 0; i < beats.size(); i++)
            if (beats[i] !== exp_data(7'(10 + i))) bad++;
        tests++;
        if (beats.size() != 6 || bad != 0 || raddrs.size() != 6) begin
            fails++;
            $display("FAIL ignored_start_data: got beats=%0d bad=%0d reads=%0d expected 6,0,6",
                     beats.size(), bad, raddrs.size());
        end
        tests++;
        if (done_cnt != 1) begin
            fails++;
            $display("FAIL ignored_start_done: got %0d DONE pulses expected 1", done_cnt);
        end
    endtask

    task automatic test_reset_mid;
        int bad = 0;
        M_READY = 0;
        @(negedge CLOCK);
        START = 1; START_ADDR = 7'd20; LEN = 8'd32;
        for (int c = 1; c <= 5; c++) begin
            @(negedge CLOCK);
            START = 0;
        end
        RESET = 1;
        @(negedge CLOCK);
        tests++;
        if ({BUSY, DONE, RAM_REN, RAM_RADDR, M_VALID, M_LAST, M_DATA} !== '0) begin
            fails++;
            $display("FAIL reset_mid_state: got busy=%b done=%b ren=%b raddr=%0d vld=%b data=%h expected all 0",
                     BUSY, DONE, RAM_REN, RAM_RADDR, M_VALID, M_DATA);
        end
        RESET = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge CLOCK);
            if (DONE || M_VALID || RAM_REN || BUSY) bad++;
        end
        tests++;
        if (bad != 0) begin
            fails++;
            $display("FAIL reset_mid_quiet: got %0d active cycles expected 0", bad);
        end
        run_cmd(7'd40, 8'd2, 0, 0);
        tests++;
        if (beats.size() != 2 || beats[0] !== exp_data(7'd40) || beats[1] !== exp_data(7'd41) ||
            lasts[1] !== 1'b1 || done_cnt != 1) begin
            fails++;
            $display("FAIL reset_mid_restart: got beats=%0d done=%0d expected 2 beats 40,41 and 1 DONE",
                     beats.size(), done_cnt);
        end
    endtask

    task automatic test_full_buffer;
        int bad = 0;
        run_cmd(7'd100, 8'd128, 0, 0);
        for (int i = 0; i < beats.size(); i++)
            if (beats[i] !== exp_data(7'(100 + i))) bad++;
        tests++;
        if (beats.size() != 128 || bad != 0 || raddrs.size() != 128) begin
            fails++;
            $display("FAIL full_buffer: got beats=%0d bad=%0d reads=%0d expected 128,0,128",
                     beats.size(), bad, raddrs.size());
        end
        tests++;
        if (lasts.size() != 128 || lasts[127] !== 1'b1 || done_cnt != 1) begin
            fails++;
            $display("FAIL full_buffer_end: got beats=%0d done=%0d expected last on beat 127 and 1 DONE",
                     lasts.size(), done_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_backpressure();
        test_len0();
        test_ignored_start();
        test_reset_mid();
        test_full_buffer();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
